// File: rtl/read_returner_pkg.sv
// +----------------------------------------------------------------------------+
// | types_def : shared types and constants for the read returner slice         |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package types_def;

    localparam int read_entries_log = 6;
    localparam int data_width       = 16;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } r_type;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        DONE    = 2'd2
    } entry_state_t;

endpackage

`default_nettype wire

// File: rtl/read_returner_store.sv
// +----------------------------------------------------------------------------+
// | returner_store : completion data array, one sync write / one async read    |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module returner_store #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX        = 6
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // Contents are only meaningful once the matching state entry is DONE,
    // so the array carries no reset.
    logic [DATA_WIDTH-1:0] mem [2**IDX];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/read_returner.sv
// +----------------------------------------------------------------------------+
// | read_returner : hands out read tags in order, accepts out-of-order         |
// | completions and returns read data in allocation order.                     |
// | Optional watchdog: define RETURNER_TIMEOUT_EN.                             |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module read_returner
    import types_def::*;
#(
    parameter int DATA_WIDTH     = data_width,
    parameter int READ_ENTRIES   = 64,
    parameter int IDX            = read_entries_log,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    output logic [IDX-1:0]        alloc_index,
    input  logic                  be_valid,
    input  r_type                 be_type,
    input  logic [DATA_WIDTH-1:0] be_data,
    input  logic [IDX-1:0]        be_index,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [IDX-1:0]        rsp_index,
    output logic                  wr_ack_valid,
    output logic [IDX-1:0]        wr_ack_index,
    output logic                  err_unexpected,
    output logic                  timeout_err
);

    localparam logic [IDX:0] FULL_COUNT = (IDX+1)'(READ_ENTRIES);

    entry_state_t   state [READ_ENTRIES];
    logic [IDX-1:0] head;
    logic [IDX-1:0] tail;
    logic [IDX:0]   count;

    logic alloc_fire;
    logic retire;
    logic rd_cpl;
    logic wr_cpl;
    logic cpl_ok;

    assign alloc_ready = (count != FULL_COUNT);
    assign alloc_index = head;
    assign alloc_fire  = alloc_valid && alloc_ready;

    assign rsp_valid   = (state[tail] == DONE);
    assign rsp_index   = tail;
    assign retire      = rsp_valid && rsp_ready;

    assign rd_cpl      = be_valid && (be_type == READ);
    assign wr_cpl      = be_valid && (be_type == WRITE);
    assign cpl_ok      = rd_cpl && (state[be_index] == PENDING);

    // The three state updates never hit the same entry: head is FREE (so it
    // can't accept a completion), and tail is only retired once DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_ENTRIES; i++) begin
                state[i] <= FREE;
            end
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            wr_ack_valid   <= 1'b0;
            wr_ack_index   <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (cpl_ok) begin
                state[be_index] <= DONE;
            end
            if (rd_cpl && !cpl_ok) begin
                err_unexpected <= 1'b1;
            end
            if (retire) begin
                state[tail] <= FREE;
                tail        <= tail + IDX'(1);
            end
            if (alloc_fire) begin
                state[head] <= PENDING;
                head        <= head + IDX'(1);
            end
            case ({alloc_fire, retire})
                2'b10:   count <= count + (IDX+1)'(1);
                2'b01:   count <= count - (IDX+1)'(1);
                default: count <= count;
            endcase
            wr_ack_valid <= wr_cpl;
            if (wr_cpl) begin
                wr_ack_index <= be_index;
            end
        end
    end

    returner_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX        (IDX)
    ) u_store (
        .clk     (clk),
        .wr_en   (cpl_ok),
        .wr_addr (be_index),
        .wr_data (be_data),
        .rd_addr (tail),
        .rd_data (rsp_data)
    );

`ifdef RETURNER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_flag;
    logic          tail_waiting;

    assign tail_waiting = (count != '0) && (state[tail] == PENDING);

    // Saturates at TIMEOUT_CYCLES; the flag is set on the edge that gets there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else if (!tail_waiting || retire) begin
            tmo_cnt  <= '0;
        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_cnt  <= TW'(TIMEOUT_CYCLES);
            tmo_flag <= 1'b1;
        end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
            tmo_cnt  <= tmo_cnt + TW'(1);
        end
    end

    assign timeout_err = tmo_flag;
`else
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_read_returner.sv
// Self-checking bench for read_returner: directed scenarios plus randomized
// traffic against an allocation-order queue model.
`default_nettype none

module tb_read_returner;
    import types_def::*;

    localparam int N    = 64;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [5:0]  alloc_index;
    logic        be_valid = 1'b0;
    r_type       be_type = READ;
    logic [15:0] be_data = '0;
    logic [5:0]  be_index = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [5:0]  rsp_index;
    logic        wr_ack_valid;
    logic [5:0]  wr_ack_index;
    logic        err_unexpected;
    logic        timeout_err;

    read_returner #(
        .DATA_WIDTH     (16),
        .READ_ENTRIES   (N),
        .IDX            (6),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_index    (alloc_index),
        .be_valid       (be_valid),
        .be_type        (be_type),
        .be_data        (be_data),
        .be_index       (be_index),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_index      (rsp_index),
        .wr_ack_valid   (wr_ack_valid),
        .wr_ack_index   (wr_ack_index),
        .err_unexpected (err_unexpected),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: outstanding tags in allocation order plus per-tag status.
    int          q[$];
    int          st[N];          // 0 free, 1 waiting for data, 2 data returned
    logic [15:0] mdata[N];
    int          next_tag;
    bit          m_err;
    bit          m_ack;
    int          m_ack_idx;
    int          m_tmo;
    bit          m_terr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < N; i++) begin
            st[i]    = 0;
            mdata[i] = '0;
        end
        next_tag  = 0;
        m_err     = 0;
        m_ack     = 0;
        m_ack_idx = 0;
        m_tmo     = 0;
        m_terr    = 0;
    endtask

    function automatic bit exp_rsp_valid();
        return (q.size() > 0) && (st[q[0]] == 2);
    endfunction

    task automatic check_outputs();
        check("alloc_ready", alloc_ready, q.size() != N);
        check("alloc_index", alloc_index, next_tag);
        check("rsp_valid", rsp_valid, exp_rsp_valid());
        check("rsp_index", rsp_index, (q.size() > 0) ? q[0] : next_tag);
        if (exp_rsp_valid()) check("rsp_data", rsp_data, mdata[q[0]]);
        check("wr_ack_valid", wr_ack_valid, m_ack);
        check("wr_ack_index", wr_ack_index, m_ack_idx);
        check("err_unexpected", err_unexpected, m_err);
`ifdef RETURNER_TIMEOUT_EN
        check("timeout_err", timeout_err, m_terr);
`else
        check("timeout_err", timeout_err, 0);
`endif
    endtask

    task automatic model_step();
        bit grant;
        bit ret;
        bit waiting;
        grant   = alloc_valid && (q.size() != N);
        ret     = exp_rsp_valid() && rsp_ready;
        waiting = (q.size() > 0) && (st[q[0]] == 1);
        if (waiting) begin
            if (m_tmo + 1 >= TMO) m_terr = 1;
            m_tmo = (m_tmo + 1 > TMO) ? TMO : m_tmo + 1;
        end else begin
            m_tmo = 0;
        end
        if (be_valid && be_type == READ) begin
            if (st[be_index] == 1) begin
                st[be_index]    = 2;
                mdata[be_index] = be_data;
            end else begin
                m_err = 1;
            end
        end
        if (ret) begin
            st[q[0]] = 0;
            void'(q.pop_front());
        end
        if (grant) begin
            st[next_tag] = 1;
            q.push_back(next_tag);
            next_tag = (next_tag + 1) % N;
        end
        m_ack = be_valid && (be_type == WRITE);
        if (m_ack) m_ack_idx = be_index;
    endtask

    task automatic cycle(input bit av, input bit bv, input r_type bt,
                         input logic [15:0] bd, input int bi, input bit rr);
        logic [31:0] b32;
        b32         = bi;
        alloc_valid = av;
        be_valid    = bv;
        be_type     = bt;
        be_data     = bd;
        be_index    = b32[5:0];
        rsp_ready   = rr;
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) cycle(0, 0, READ, '0, 0, rr);
    endtask

    // Asynchronous: outputs checked before any clock edge while rst is high.
    task automatic do_reset();
        alloc_valid = 0; be_valid = 0; rsp_ready = 0;
        rst = 1'b1;
        #2;
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_alloc_index", alloc_index, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_wr_ack_valid", wr_ack_valid, 0);
        check("rst_wr_ack_index", wr_ack_index, 0);
        check("rst_err", err_unexpected, 0);
        check("rst_timeout", timeout_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() > 0 && n < budget) begin
            cycle(0, 0, READ, '0, 0, 1);
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        int perm[$];
        int pend[$];
        int r;
        int j;
        int tmp;

        model_reset();
        do_reset();

        // Three tags, completed out of order.
        cycle(1, 0, READ, '0, 0, 1);
        cycle(1, 0, READ, '0, 0, 1);
        cycle(1, 0, READ, '0, 0, 1);
        cycle(0, 1, READ, 16'h000C, 2, 1);
        cycle(0, 1, READ, 16'h000A, 0, 0);
        check("lat_valid", rsp_valid, 1);
        check("lat_data", rsp_data, 16'h000A);
        cycle(0, 1, READ, 16'h000B, 1, 1);
        drain(10);

        // Fill, then retire with alloc held: grant only on the following cycle.
        do_reset();
        for (int i = 0; i < N; i++) cycle(1, 0, READ, '0, 0, 0);
        check("full_ready", alloc_ready, 0);
        cycle(0, 1, READ, 16'h1234, 0, 0);
        cycle(1, 0, READ, '0, 0, 1);
        check("wrap_ready", alloc_ready, 1);
        check("wrap_index", alloc_index, 0);
        cycle(1, 0, READ, '0, 0, 0);
        check("wrap_full", alloc_ready, 0);
        perm = q;
        for (int i = perm.size() - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        foreach (perm[i]) cycle(0, 1, READ, 16'($urandom), perm[i], $urandom_range(0, 1));
        drain(100);

        // Write ack pulse, then unexpected completion to a FREE tag.
        cycle(0, 1, WRITE, '0, 5, 0);
        check("wack_valid", wr_ack_valid, 1);
        check("wack_index", wr_ack_index, 5);
        cycle(0, 0, READ, '0, 0, 0);
        check("wack_pulse", wr_ack_valid, 0);
        cycle(0, 1, READ, 16'hDEAD, 9, 0);
        check("err_set", err_unexpected, 1);
        idle(3, 1);
        check("err_sticky", err_unexpected, 1);

        // Stall a DONE tail, then alloc and retire concurrently.
        do_reset();
        cycle(1, 0, READ, '0, 0, 0);
        cycle(1, 1, READ, 16'h00A5, 0, 0);
        cycle(0, 1, READ, 16'h005A, 1, 0);
        idle(10, 0);
        cycle(1, 0, READ, '0, 0, 1);
        cycle(1, 0, READ, '0, 0, 1);
        check("concurrent_outstanding", q.size(), 2);

        // Watchdog: leave the tail tag waiting.
        do_reset();
        cycle(1, 0, READ, '0, 0, 0);
        idle(TMO + 4, 0);
        cycle(0, 1, READ, 16'h0F0F, 0, 1);
        drain(5);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            pend.delete();
            foreach (q[i]) if (st[q[i]] == 1) pend.push_back(q[i]);
            r = $urandom_range(0, 199);
            if (r < 100 && pend.size() > 0)
                cycle($urandom_range(0, 1), 1, READ, 16'($urandom),
                      pend[$urandom_range(0, pend.size() - 1)], $urandom_range(0, 3) != 0);
            else if (r == 100)
                cycle($urandom_range(0, 1), 1, READ, 16'($urandom),
                      $urandom_range(0, N - 1), $urandom_range(0, 3) != 0);
            else if (r < 130)
                cycle($urandom_range(0, 1), 1, WRITE, 16'($urandom),
                      $urandom_range(0, N - 1), $urandom_range(0, 3) != 0);
            else
                cycle($urandom_range(0, 1), 0, READ, '0, 0, $urandom_range(0, 3) != 0);
        end

        // Reset with traffic outstanding: nothing may come out afterwards.
        do_reset();
        idle(8, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/read_returner.md
Name: read_returner

Overview:
- Reorder/return stage on the far side of the back end's returner interface.
- Hands out read index tags to the front end in program order.
- Accepts out-of-order read completions (data + index) and write completions from the burst handler.
- Delivers read data to the requester strictly in allocation order over a valid/ready handshake, and pulses write acknowledgements.

Parameters:
- DATA_WIDTH, 16, width of one returned data word (equals data_width in types_def).
- READ_ENTRIES, 64, number of outstanding read tags; power of two.
- IDX, 6, tag width = $clog2(READ_ENTRIES) (equals read_entries_log).
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with RETURNER_TIMEOUT_EN.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  front end requests a read tag.
- alloc_ready  out  1  a tag is free.
- alloc_index  out  IDX  tag granted on alloc_valid && alloc_ready.
- be_valid  in  1  burst-handler completion strobe (returner_valid).
- be_type  in  r_type  READ or WRITE completion.
- be_data  in  DATA_WIDTH  read data (don't-care for WRITE).
- be_index  in  IDX  tag of the completing request.
- rsp_valid  out  1  in-order read response available.
- rsp_ready  in  1  requester accepts the response.
- rsp_data  out  DATA_WIDTH  response data.
- rsp_index  out  IDX  tag of the response.
- wr_ack_valid  out  1  one-cycle write-done pulse.
- wr_ack_index  out  IDX  tag of the acknowledged write.
- err_unexpected  out  1  sticky: completion for a tag not PENDING.
- timeout_err  out  1  sticky watchdog flag (see Optional Feature).

Behaviour:
- Storage: circular array of READ_ENTRIES entries. Each entry holds a state {FREE, PENDING, DONE} and a DATA_WIDTH data word.
- Pointers: head (alloc), tail (retire), count (0..READ_ENTRIES), all registers.
- Reset: all entries FREE; head = tail = count = 0; alloc_ready = 1; rsp_valid = 0; wr_ack_valid = 0; err_unexpected = 0; timeout_err = 0; wr_ack_index = 0.
- Alloc:
  - alloc_ready = (count != READ_ENTRIES); alloc_index = head (combinational).
  - On alloc_valid && alloc_ready: entry[head] := PENDING; head := head+1, wrapping from READ_ENTRIES-1 to 0.
  - No bypass: when full, alloc_ready stays 0 even if a retire happens in the same cycle.
- Read completion: be_valid && be_type==READ.
  - If entry[be_index] == PENDING: data := be_data and state := DONE at the clock edge.
  - Otherwise (FREE or DONE): the entry is unchanged and err_unexpected is set and held until rst.
- Write completion: be_valid && be_type==WRITE.
  - Next cycle: wr_ack_valid = 1 and wr_ack_index = be_index, for exactly one cycle.
  - No array state is touched.
  - Back-to-back writes give back-to-back pulses.
- Retire:
  - rsp_valid = (entry[tail] == DONE); rsp_data = entry[tail].data; rsp_index = tail (all combinational from registers).
  - Completion-to-response latency: 1 cycle when the completed tag is at tail.
  - On rsp_valid && rsp_ready: entry[tail] := FREE; tail := tail+1 (wrap); count decremented.
  - rsp_valid with rsp_ready low: outputs hold stable.
- Simultaneous events:
  - Alloc and retire in the same cycle: count unchanged.
  - Completion to the tail entry in the same cycle as a stalled rsp: visible next cycle.
  - Completion and alloc on different tags: independent.
  - Completion to the tag being allocated in the same cycle: it is FREE, so err_unexpected is set.
- Reset mid-operation: all outstanding tags are discarded; no response or ack is emitted after rst deasserts until new activity.

Optional Feature:
- Macro RETURNER_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle while count != 0 and entry[tail] == PENDING.
  - It clears on retire or when entry[tail] becomes DONE.
  - When it reaches TIMEOUT_CYCLES, timeout_err is set (sticky until rst) and the counter saturates.
- Undefined: no counter logic; timeout_err is tied to 0.

Decomposition:
- types_def package: r_type (READ, WRITE) is reused; add entry_state_t enum {FREE, PENDING, DONE} and constants read_entries_log and data_width.
- One sub-module, returner_store: the data array with one synchronous write port (completion) and one combinational read port (tail). The state vector and pointers stay in the top module.

Test Plan:
- Reset, then 3 allocs: tags 0,1,2; complete reads in order 2 (0xC), 0 (0xA), 1 (0xB) -> responses 0xA/0, 0xB/1, 0xC/2 in that order; response 0 appears 1 cycle after its completion.
- Allocate 64 tags -> alloc_ready=0 with count=64. Retire tag 0 with alloc_valid held -> no grant that cycle. Next cycle a grant with alloc_index=0 (wrap) while head, tail and count stay consistent.
- Write completion be_index=5 -> wr_ack_valid=1 with wr_ack_index=5 for exactly 1 cycle; rsp_valid is unaffected.
- Completion to a FREE tag 9 -> err_unexpected=1 and sticky; array and rsp_valid unchanged.
- rsp_ready held low 10 cycles with tag 0 DONE -> rsp_data/rsp_index stable. Concurrent alloc and retire -> count constant.
- With RETURNER_TIMEOUT_EN and TIMEOUT_CYCLES=16: tag 0 left PENDING -> timeout_err=1 at cycle 16. Assert rst mid-stream -> all outputs return to reset values.
